// File: rtl/axil_conf_queue.sv
// AXI4-Lite configuration slave: NREG byte-strobed registers; writes to register 0
// queue a snapshot of the whole file for the accelerator. Optional macro: CONF_STATUS_EN.
module axil_conf_queue #(
  parameter int          NREG      = 4,
  parameter int          QDEPTH    = 4,
  parameter logic [31:0] ADDR_BASE = 32'd0
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic [31:0]          S_AXI_AWADDR,
  input  logic                 S_AXI_AWVALID,
  output logic                 S_AXI_AWREADY,
  input  logic [31:0]          S_AXI_WDATA,
  input  logic [3:0]           S_AXI_WSTRB,
  input  logic                 S_AXI_WVALID,
  output logic                 S_AXI_WREADY,
  output logic [1:0]           S_AXI_BRESP,
  output logic                 S_AXI_BVALID,
  input  logic                 S_AXI_BREADY,
  input  logic [31:0]          S_AXI_ARADDR,
  input  logic                 S_AXI_ARVALID,
  output logic                 S_AXI_ARREADY,
  output logic [31:0]          S_AXI_RDATA,
  output logic [1:0]           S_AXI_RRESP,
  output logic                 S_AXI_RVALID,
  input  logic                 S_AXI_RREADY,
  output logic                 CONFIG_VALID,
  input  logic                 CONFIG_READY,
  output logic [32*NREG-1:0]   CONFIG_DATA,
  output logic                 CONFIG_IRQ
);

  localparam int L  = $clog2(NREG);
  localparam int IW = L + 1;
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int DW = 32 * NREG;

  // Address bits above the word-index field must match the base; [L+2:0] are ignored here.
  localparam logic [31:0]    KEEP_MASK = ~((32'd1 << (IW + 2)) - 32'd1);
  localparam logic [IW-1:0]  NREG_IDX  = IW'(NREG);
  localparam logic [CW-1:0]  QFULL     = CW'(QDEPTH);
  localparam logic [1:0]     RESP_OKAY = 2'b00;
  localparam logic [1:0]     RESP_SLV  = 2'b10;

  logic [31:0]   regs [NREG];
  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic          rvalid_q;
  logic [31:0]   rdata_q;
  logic [1:0]    rresp_q;
  logic [DW-1:0] q_mem [QDEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   cycle_cnt;

  logic [IW-1:0] wr_idx;
  logic          wr_good;
  logic          wr_hs;
  logic [31:0]   wr_old;
  logic [31:0]   wr_merged;
  logic          push_req;
  logic          q_full;
  logic          push;
  logic          drop;
  logic          pop;
  logic [DW-1:0] snap;

  logic [IW-1:0] rd_idx;
  logic          rd_base_ok;
  logic          rd_hs;
  logic          rd_good;
  logic [31:0]   rd_word;

  // Every channel transfers on the cycle where valid and ready are both high at the
  // rising edge; a raised valid stays up with stable payload until that edge.
  assign wr_hs         = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
  assign S_AXI_AWREADY = wr_hs;
  assign S_AXI_WREADY  = wr_hs;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;

  assign rd_hs         = S_AXI_ARVALID && !rvalid_q;
  assign S_AXI_ARREADY = !rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign wr_idx  = S_AXI_AWADDR[L+2:2];
  assign wr_good = ((S_AXI_AWADDR & KEEP_MASK) == (ADDR_BASE & KEEP_MASK)) && (wr_idx < NREG_IDX);
  assign wr_old  = regs[wr_idx[L-1:0]];

  always_comb begin
    wr_merged = wr_old;
    for (int b = 0; b < 4; b++) begin
      if (S_AXI_WSTRB[b]) wr_merged[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
    end
  end

  // The snapshot carries the freshly merged reg 0 rather than its stale value.
  always_comb begin
    snap = '0;
    for (int i = 0; i < NREG; i++) snap[32*i +: 32] = regs[i];
    snap[31:0] = wr_merged;
  end

  assign push_req = wr_hs && wr_good && (wr_idx == '0);
  assign q_full   = (count_q == QFULL);
  assign push     = push_req && !q_full;
  assign drop     = push_req && q_full;
  assign pop      = (count_q != '0) && CONFIG_READY;

  assign CONFIG_VALID = (count_q != '0);
  assign CONFIG_DATA  = (count_q != '0) ? q_mem[rd_ptr_q] : '0;
  assign CONFIG_IRQ   = (count_q == '0) && CONFIG_READY;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (!wr_good || drop) ? RESP_SLV : RESP_OKAY;
        if (wr_good) regs[wr_idx[L-1:0]] <= wr_merged;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) q_mem[wr_ptr_q] <= snap;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Measures how long the accelerator has been busy with the current command.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      cycle_cnt <= '0;
    end else if (pop) begin
      cycle_cnt <= '0;
    end else if (!CONFIG_READY && (cycle_cnt != 32'hFFFF_FFFF)) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign rd_idx     = S_AXI_ARADDR[L+2:2];
  assign rd_base_ok = ((S_AXI_ARADDR & KEEP_MASK) == (ADDR_BASE & KEEP_MASK));

`ifdef CONF_STATUS_EN
  logic [7:0] drop_q;
  logic       rd_stat_q;
  logic       stat_clr;

  assign stat_clr = rvalid_q && S_AXI_RREADY && rd_stat_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      drop_q    <= '0;
      rd_stat_q <= 1'b0;
    end else begin
      if (rd_hs) rd_stat_q <= rd_base_ok && (rd_idx == NREG_IDX);
      if (stat_clr) begin
        drop_q <= drop ? 8'd1 : 8'd0;
      end else if (drop && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end
`endif

  always_comb begin
    rd_good = 1'b0;
    rd_word = '0;
    if (rd_base_ok && (rd_idx < NREG_IDX)) begin
      rd_good = 1'b1;
      rd_word = (rd_idx == '0) ? cycle_cnt : regs[rd_idx[L-1:0]];
    end
`ifdef CONF_STATUS_EN
    else if (rd_base_ok && (rd_idx == NREG_IDX)) begin
      rd_good = 1'b1;
      rd_word = {16'b0, drop_q, 3'b0, 5'(count_q)};
    end
`endif
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      if (rvalid_q && S_AXI_RREADY) rvalid_q <= 1'b0;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
        rresp_q  <= rd_good ? RESP_OKAY : RESP_SLV;
      end
    end
  end

endmodule

// File: tb/tb_axil_conf_queue.sv
// Directed bench for axil_conf_queue (NREG=4, QDEPTH=4, ADDR_BASE=0); status checks
// switch with CONF_STATUS_EN.
module tb_axil_conf_queue;

  logic         ACLK;
  logic         ARESETN;
  logic [31:0]  S_AXI_AWADDR;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [31:0]  S_AXI_ARADDR;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic         CONFIG_VALID;
  logic         CONFIG_READY;
  logic [127:0] CONFIG_DATA;
  logic         CONFIG_IRQ;

  int checks = 0;
  int errors = 0;

  axil_conf_queue #(.NREG(4), .QDEPTH(4), .ADDR_BASE(32'd0)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .CONFIG_VALID(CONFIG_VALID), .CONFIG_READY(CONFIG_READY),
    .CONFIG_DATA(CONFIG_DATA), .CONFIG_IRQ(CONFIG_IRQ)
  );

  // clock / reset
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks; all start shortly after a rising edge
  task automatic wr_issue(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!S_AXI_AWREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk("aw_handshake", {31'b0, S_AXI_AWREADY}, 32'd1);
    @(posedge ACLK);
    #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
  endtask

  task automatic wr_resp(output logic [1:0] resp);
    int n;
    n = 0;
    @(negedge ACLK);
    while (!S_AXI_BVALID && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk("b_valid", {31'b0, S_AXI_BVALID}, 32'd1);
    resp = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK);
    #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    wr_issue(addr, data, strb);
    wr_resp(resp);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!S_AXI_ARREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk("ar_handshake", {31'b0, S_AXI_ARREADY}, 32'd1);
    @(posedge ACLK);
    #1;
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    chk("r_valid_latency", {31'b0, S_AXI_RVALID}, 32'd1);
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK);
    #1;
    S_AXI_RREADY = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rr;
  logic [1:0]  br;

  initial begin
    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    CONFIG_READY = 1'b1;
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;

    // reset state
    @(negedge ACLK);
    chk("rst_bvalid", {31'b0, S_AXI_BVALID}, 32'd0);
    chk("rst_rvalid", {31'b0, S_AXI_RVALID}, 32'd0);
    chk("rst_cfg_valid", {31'b0, CONFIG_VALID}, 32'd0);
    chk("rst_resps", {28'b0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
    chk("rst_rdata", S_AXI_RDATA, 32'd0);
    chk("rst_cfg_data_lo", CONFIG_DATA[31:0], 32'd0);
    chk("rst_cfg_data_hi", CONFIG_DATA[127:96], 32'd0);
    chk("rst_irq", {31'b0, CONFIG_IRQ}, 32'd1);
    @(posedge ACLK);
    #1;
    for (int i = 1; i < 4; i++) begin
      axi_read(32'(i * 4), rd, rr);
      chk("rst_reg_read", rd, 32'd0);
      chk("rst_reg_rresp", {30'b0, rr}, 32'd0);
    end

    // byte strobes; the response is held while BREADY stays low
    axi_write(32'h4, 32'h1111_2222, 4'b0011, br);
    chk("strb_lo_bresp", {30'b0, br}, 32'd0);
    wr_issue(32'h4, 32'hAAAA_BBBB, 4'b1100);
    @(negedge ACLK);
    @(negedge ACLK);
    chk("bvalid_held", {31'b0, S_AXI_BVALID}, 32'd1);
    @(posedge ACLK);
    #1;
    wr_resp(br);
    chk("strb_hi_bresp", {30'b0, br}, 32'd0);
    axi_read(32'h4, rd, rr);
    chk("strb_merge", rd, 32'hAAAA_2222);
    chk("strb_rresp", {30'b0, rr}, 32'd0);

    // fill queue with accelerator busy; the fifth push is refused
    CONFIG_READY = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      axi_write(32'h0, 32'(i), 4'hF, br);
      chk("push_bresp", {30'b0, br}, (i <= 4) ? 32'd0 : 32'd2);
    end
    @(negedge ACLK);
    chk("full_cfg_valid", {31'b0, CONFIG_VALID}, 32'd1);
    chk("full_head_reg0", CONFIG_DATA[31:0], 32'd1);
    chk("full_head_reg1", CONFIG_DATA[63:32], 32'hAAAA_2222);
    chk("full_irq", {31'b0, CONFIG_IRQ}, 32'd0);
    @(posedge ACLK);
    #1 CONFIG_READY = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge ACLK);
      chk("pop_valid", {31'b0, CONFIG_VALID}, 32'd1);
      chk("pop_head", CONFIG_DATA[31:0], 32'(k));
    end
    @(negedge ACLK);
    chk("drained_valid", {31'b0, CONFIG_VALID}, 32'd0);
    chk("drained_irq", {31'b0, CONFIG_IRQ}, 32'd1);
    @(posedge ACLK);
    #1;

    // push and pop on the same edge keep one entry
    CONFIG_READY = 1'b0;
    axi_write(32'h0, 32'h10, 4'hF, br);
    chk("pp_first_bresp", {30'b0, br}, 32'd0);
    CONFIG_READY = 1'b1;
    wr_issue(32'h0, 32'h20, 4'hF);
    @(negedge ACLK);
    chk("pp_valid", {31'b0, CONFIG_VALID}, 32'd1);
    chk("pp_head", CONFIG_DATA[31:0], 32'h20);
    wr_resp(br);
    chk("pp_bresp", {30'b0, br}, 32'd0);
    @(negedge ACLK);
    chk("pp_drained", {31'b0, CONFIG_VALID}, 32'd0);
    @(posedge ACLK);
    #1;

    // address decode
    axi_write(32'h100, 32'hDEAD_BEEF, 4'hF, br);
    chk("bad_wr_bresp", {30'b0, br}, 32'd2);
    chk("bad_wr_no_push", {31'b0, CONFIG_VALID}, 32'd0);
    axi_write(32'h104, 32'hDEAD_BEEF, 4'hF, br);
    chk("alias_wr_bresp", {30'b0, br}, 32'd2);
    axi_read(32'h4, rd, rr);
    chk("alias_no_change", rd, 32'hAAAA_2222);
    axi_read(32'h100, rd, rr);
    chk("bad_rd_data", rd, 32'd0);
    chk("bad_rd_rresp", {30'b0, rr}, 32'd2);
    axi_write(32'hC, 32'h3333_3333, 4'hF, br);
    chk("reg3_bresp", {30'b0, br}, 32'd0);
    axi_read(32'hC, rd, rr);
    chk("reg3_read", rd, 32'h3333_3333);
    axi_write(32'h10, 32'h5555_5555, 4'hF, br);
    chk("stat_wr_bresp", {30'b0, br}, 32'd2);
`ifndef CONF_STATUS_EN
    axi_read(32'h10, rd, rr);
    chk("stat_off_rdata", rd, 32'd0);
    chk("stat_off_rresp", {30'b0, rr}, 32'd2);
`endif

    // cycle counter: cleared by the last pop, then 37 busy cycles
    axi_read(32'h0, rd, rr);
    chk("cnt_idle", rd, 32'd0);
    CONFIG_READY = 1'b0;
    repeat (37) @(posedge ACLK);
    #1 CONFIG_READY = 1'b1;
    axi_read(32'h0, rd, rr);
    chk("cnt_37", rd, 32'd37);

    // saturation near the top
    CONFIG_READY = 1'b0;
    force dut.cycle_cnt = 32'hFFFF_FFFD;
    @(posedge ACLK);
    #1 release dut.cycle_cnt;
    repeat (5) @(posedge ACLK);
    #1;
    axi_read(32'h0, rd, rr);
    chk("cnt_saturate", rd, 32'hFFFF_FFFF);

    // refused pushes with a full queue
`ifdef CONF_STATUS_EN
    axi_read(32'h10, rd, rr);
    chk("stat_pre_clear", rd, 32'h0000_0100);
`endif
    for (int i = 0; i < 7; i++) begin
      axi_write(32'h0, 32'(32'h40 + i), 4'hF, br);
      chk("drop_bresp", {30'b0, br}, (i < 4) ? 32'd0 : 32'd2);
    end
`ifdef CONF_STATUS_EN
    axi_read(32'h10, rd, rr);
    chk("stat_drops", rd, 32'h0000_0304);
    chk("stat_rresp", {30'b0, rr}, 32'd0);
    axi_read(32'h10, rd, rr);
    chk("stat_cleared", rd, 32'h0000_0004);
`endif
    chk("drop_head", CONFIG_DATA[31:0], 32'h40);

    // reset with a write response pending flushes everything
    CONFIG_READY = 1'b1;
    wr_issue(32'h8, 32'h7777_7777, 4'hF);
    ARESETN = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    @(negedge ACLK);
    chk("mid_rst_bvalid", {31'b0, S_AXI_BVALID}, 32'd0);
    chk("mid_rst_cfg_valid", {31'b0, CONFIG_VALID}, 32'd0);
    chk("mid_rst_irq", {31'b0, CONFIG_IRQ}, 32'd1);
    @(posedge ACLK);
    #1;
    axi_read(32'h0, rd, rr);
    chk("mid_rst_cnt", rd, 32'd0);
    axi_read(32'h4, rd, rr);
    chk("mid_rst_reg1", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
